// File: rtl/dcache_direct_wb.sv
// Direct-mapped, write-back, write-allocate data cache.
// Processor side: a request is held by the processor while proc_stall is high;
// it completes in the cycle where proc_stall is low. Memory side: mem_read or
// mem_write stays high with stable address/data until mem_ready is sampled high
// at a rising edge, and drops in the following cycle.
module dcache_direct_wb #(
    parameter  int NUM_BLOCKS = 8,
    localparam int IW         = $clog2(NUM_BLOCKS),
    localparam int TW         = 28 - IW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic         proc_stall,
    output logic [31:0]  proc_rdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);

    typedef enum logic [1:0] {
        S_COMPARE   = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] dirty_q;
    logic [TW-1:0]         tag_q  [NUM_BLOCKS];
    logic [127:0]          data_q [NUM_BLOCKS];

    logic [IW-1:0]  idx;
    logic [TW-1:0]  req_tag;
    logic [1:0]     word;
    logic [127:0]   line_data;
    logic           hit;
    logic           req;

    // Address decode, hit detection and the combinational read path.
    always_comb begin
        idx        = proc_addr[IW+1:2];
        req_tag    = proc_addr[29:IW+2];
        word       = proc_addr[1:0];
        line_data  = data_q[idx];
        hit        = valid_q[idx] && (tag_q[idx] == req_tag);
        req        = proc_read || proc_write;
        proc_rdata = line_data[{word, 5'b0} +: 32];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_COMPARE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and processor stall.
    always_comb begin
        state_d    = state_q;
        proc_stall = 1'b1;
        case (state_q)
            S_COMPARE: begin
                proc_stall = req && !hit;
                if (req && !hit) begin
                    state_d = (valid_q[idx] && dirty_q[idx]) ? S_WRITEBACK : S_ALLOCATE;
                end
            end
            S_WRITEBACK: begin
                if (mem_ready) state_d = S_ALLOCATE;
            end
            S_ALLOCATE: begin
                if (mem_ready) state_d = S_COMPARE;
            end
            default: state_d = S_COMPARE;
        endcase
    end

    // Registered memory request: strobes follow the next state, address and
    // write data are captured once on entry and then held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_read  <= (state_d == S_ALLOCATE);
            mem_write <= (state_d == S_WRITEBACK);
            if (state_q == S_COMPARE && state_d == S_WRITEBACK) begin
                mem_addr  <= {tag_q[idx], idx};
                mem_wdata <= line_data;
            end else if (state_q != S_ALLOCATE && state_d == S_ALLOCATE) begin
                mem_addr <= proc_addr[29:2];
            end
        end
    end

    // Line storage: write hits merge one word, a completed fill loads a clean line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (state_q == S_COMPARE && proc_write && hit) begin
            data_q[idx][{word, 5'b0} +: 32] <= proc_wdata;
            dirty_q[idx]                    <= 1'b1;
        end else if (state_q == S_ALLOCATE && mem_ready) begin
            data_q[idx]  <= mem_rdata;
            tag_q[idx]   <= req_tag;
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dcache_direct_wb.sv
// Directed bench for dcache_direct_wb with a transaction-level cache and
// memory model; every cycle of every access is compared against the model.
module tb_dcache_direct_wb;
  localparam int IW = 3;
  localparam int TW = 25;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         proc_read = 1'b0;
  logic         proc_write = 1'b0;
  logic [29:0]  proc_addr = '0;
  logic [31:0]  proc_wdata = '0;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;

  dcache_direct_wb #(.NUM_BLOCKS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_stall(proc_stall), .proc_rdata(proc_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard state
  int checks = 0;
  int failures = 0;

  // cache model
  logic [7:0]    m_valid;
  logic [7:0]    m_dirty;
  logic [TW-1:0] m_tag  [8];
  logic [127:0]  m_data [8];
  // memory model: blocks never written back hold a pattern derived from the address
  logic [127:0]  mem_model [logic [27:0]];

  // results of the most recent access
  int            last_stall;
  logic [27:0]   last_wb_addr;
  logic [127:0]  last_wb_data;
  logic [31:0]   last_rdata;

  function automatic logic [127:0] block_of(input logic [27:0] ba);
    logic [127:0] b;
    for (int w = 0; w < 4; w++) b[32*w +: 32] = 32'h1000_0000 | 32'({ba, 2'(w)});
    return b;
  endfunction

  function automatic logic [127:0] mem_fetch(input logic [27:0] ba);
    if (mem_model.exists(ba)) return mem_model[ba];
    return block_of(ba);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = '0;
    m_dirty = '0;
    for (int i = 0; i < 8; i++) begin
      m_tag[i]  = '0;
      m_data[i] = '0;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 read, 1 write, 2 read+write (behaves as write).
  // lat: memory answers lat cycles after its request rises.
  task automatic access(input int kind, input logic [29:0] a, input logic [31:0] wd, input int lat);
    logic [IW-1:0] idx;
    logic [TW-1:0] tg;
    int            w;
    logic          wr;
    logic          hit;
    logic [27:0]   wb_a;
    logic [127:0]  wb_d;
    logic [127:0]  fill;
    idx = a[IW+1:2];
    tg  = a[29:IW+2];
    w   = int'(a[1:0]);
    wr  = (kind != 0);
    hit = m_valid[idx] && (m_tag[idx] == tg);
    proc_read  = (kind != 1);
    proc_write = wr;
    proc_addr  = a;
    proc_wdata = wd;
    last_stall = 0;
    mem_ready  = hit ? 1'($urandom_range(0, 1)) : 1'b0;

    if (!hit) begin
      @(negedge clk);
      chk("miss_stall", proc_stall, 1'b1);
      chk("miss_mem_read", mem_read, 1'b0);
      chk("miss_mem_write", mem_write, 1'b0);
      last_stall++;
      next_cycle();
      if (m_valid[idx] && m_dirty[idx]) begin
        wb_a = {m_tag[idx], idx};
        wb_d = m_data[idx];
        for (int k = 0; k <= lat; k++) begin
          mem_ready = (k == lat);
          @(negedge clk);
          chk("wb_stall", proc_stall, 1'b1);
          chk("wb_mem_write", mem_write, 1'b1);
          chk("wb_mem_read", mem_read, 1'b0);
          chk("wb_mem_addr", mem_addr, wb_a);
          chk("wb_mem_wdata", mem_wdata, wb_d);
          last_stall++;
          next_cycle();
        end
        mem_model[wb_a] = wb_d;
        last_wb_addr = wb_a;
        last_wb_data = wb_d;
      end
      fill = mem_fetch(a[29:2]);
      for (int k = 0; k <= lat; k++) begin
        mem_ready = (k == lat);
        mem_rdata = (k == lat) ? fill : ~fill;
        @(negedge clk);
        chk("fill_stall", proc_stall, 1'b1);
        chk("fill_mem_read", mem_read, 1'b1);
        chk("fill_mem_write", mem_write, 1'b0);
        chk("fill_mem_addr", mem_addr, a[29:2]);
        last_stall++;
        next_cycle();
      end
      mem_ready = 1'b0;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
      m_data[idx]  = fill;
    end

    // completing cycle: hit in COMPARE
    @(negedge clk);
    chk("done_stall", proc_stall, 1'b0);
    chk("done_mem_read", mem_read, 1'b0);
    chk("done_mem_write", mem_write, 1'b0);
    if (!wr) chk("rdata", proc_rdata, m_data[idx][32*w +: 32]);
    last_rdata = proc_rdata;
    next_cycle();
    if (wr) begin
      m_data[idx][32*w +: 32] = wd;
      m_dirty[idx] = 1'b1;
    end
    proc_read  = 1'b0;
    proc_write = 1'b0;
    mem_ready  = 1'b0;
  endtask

  initial begin
    model_reset();
    // reset: hold low across two edges, then look at the outputs
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    chk("rst_stall", proc_stall, 1'b0);
    chk("rst_rdata", proc_rdata, 32'h0);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr", mem_addr, 28'h0);
    chk("rst_mem_wdata", mem_wdata, 128'h0);
    rst_n = 1'b1;
    next_cycle();

    // clean read miss, L = 1
    access(0, 30'h0000_0005, 32'h0, 1);
    chk("t1_stall_cycles", 32'(last_stall), 32'd3);
    chk("t1_rdata_lit", last_rdata, 32'h1000_0005);

    // write hit then read back
    access(1, 30'h0000_0005, 32'hDEAD_BEEF, 1);
    chk("t2_wr_stall_cycles", 32'(last_stall), 32'd0);
    access(0, 30'h0000_0005, 32'h0, 1);
    chk("t2_rd_stall_cycles", 32'(last_stall), 32'd0);
    chk("t2_rdata_lit", last_rdata, 32'hDEAD_BEEF);

    // conflict on the dirty line: writeback then fill, L = 2
    access(0, 30'h0000_0025, 32'h0, 2);
    chk("t3_stall_cycles", 32'(last_stall), 32'd7);
    chk("t3_wb_addr_lit", last_wb_addr, 28'h000_0001);
    chk("t3_wb_data_lit", last_wb_data, 128'h10000007_10000006_DEADBEEF_10000004);
    chk("t3_rdata_lit", last_rdata, 32'h1000_0025);

    // write miss merges into fresh line; eviction writes the merged block
    access(1, 30'h0000_0042, 32'hCAFE_F00D, 1);
    chk("t4_wr_stall_cycles", 32'(last_stall), 32'd3);
    access(0, 30'h0000_0042, 32'h0, 1);
    chk("t4_rdata_lit", last_rdata, 32'hCAFE_F00D);
    access(0, 30'h0000_0002, 32'h0, 1);
    chk("t4_wb_addr_lit", last_wb_addr, 28'h000_0010);
    chk("t4_wb_data_lit", last_wb_data, 128'h10000043_CAFEF00D_10000041_10000040);
    chk("t4_rdata_lit", last_rdata, 32'h1000_0002);

    // slow memory, L = 7
    access(0, 30'h0000_0060, 32'h0, 7);
    chk("t5_stall_cycles", 32'(last_stall), 32'd9);
    chk("t5_rdata_lit", last_rdata, 32'h1000_0060);

    // reset in the 3rd ALLOCATE cycle
    proc_read = 1'b1;
    proc_addr = 30'h0000_0084;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("t6_miss_stall", proc_stall, 1'b1);
    next_cycle();
    @(negedge clk);
    chk("t6_alloc1_mem_read", mem_read, 1'b1);
    next_cycle();
    next_cycle();
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_mem_read", mem_read, 1'b0);
    chk("t6_async_mem_addr", mem_addr, 28'h0);
    chk("t6_async_stall", proc_stall, 1'b1);
    model_reset();
    next_cycle();
    rst_n = 1'b1;
    access(0, 30'h0000_0084, 32'h0, 1);
    chk("t6_remiss_stall_cycles", 32'(last_stall), 32'd3);
    chk("t6_rdata_lit", last_rdata, 32'h1000_0084);

    // line 1 was invalidated; memory now holds the written-back block
    access(0, 30'h0000_0005, 32'h0, 1);
    chk("t7_stall_cycles", 32'(last_stall), 32'd3);
    chk("t7_rdata_lit", last_rdata, 32'hDEAD_BEEF);

    // read and write together behave as a write
    access(2, 30'h0000_0005, 32'h1234_5678, 1);
    chk("t8_both_stall_cycles", 32'(last_stall), 32'd0);
    access(0, 30'h0000_0005, 32'h0, 1);
    chk("t8_rdata_lit", last_rdata, 32'h1234_5678);

    // every index with a distinct tag, then read back with mixed latencies
    for (int i = 0; i < 8; i++)
      access(1, {25'd5, 3'(i), 2'(i)}, 32'hA500_0000 | 32'(i), i % 3);
    for (int i = 0; i < 8; i++)
      access(0, {25'd5, 3'(i), 2'(i)}, 32'h0, 1);
    chk("t9_rdata_lit", last_rdata, 32'hA500_0007);
    // conflicting tags on every index force dirty evictions
    for (int i = 0; i < 8; i++)
      access(0, {25'd9, 3'(i), 2'd0}, 32'h0, 1 + (i % 2));
    chk("t9_wb_addr_lit", last_wb_addr, {25'd5, 3'd7});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dcache_direct_wb.md
# dcache_direct_wb

Direct-mapped, write-back, write-allocate data cache that answers the pipeline's data-cache port. It is the responder for the processor's read/write/stall handshake and the initiator toward a 128-bit block memory. It sits between the core's D-cache interface and the slow memory model. An identical instance with `proc_write` tied low also serves as the I-cache.

## Interface
- `NUM_BLOCKS`, default 8: number of cache lines; power of two, at least 2. Index width `IW = log2(NUM_BLOCKS)`. Tag width `TW = 28 - IW`.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `proc_read` input 1: processor read request.
- `proc_write` input 1: processor write request.
- `proc_addr` input 30: word address. `[1:0]` is the word offset, `[IW+1:2]` the index, `[29:IW+2]` the tag.
- `proc_wdata` input 32: write data.
- `proc_stall` output 1: request not yet complete; the processor holds its request.
- `proc_rdata` output 32: read data.
- `mem_read` output 1: block read request.
- `mem_write` output 1: block write request.
- `mem_addr` output 28: block address, `{tag, index}`.
- `mem_wdata` output 128: block being written back.
- `mem_rdata` input 128: returned block.
- `mem_ready` input 1: memory completes the current request in this cycle.

## Operation
- Each line holds `valid`, `dirty`, a `TW`-bit tag and a 128-bit data block. Word `w` of a block occupies bits `[32w+31:32w]`.
- Hit: `valid[index]` is set and the stored tag equals the address tag.
- FSM states:
  - COMPARE (reset state):
    - No request, or a hit: `proc_stall = 0`.
    - Read hit: `proc_rdata` = the selected word, combinationally.
    - Write hit: the selected word is replaced by `proc_wdata` at the clock edge and `dirty` is set.
    - Miss on a dirty line: go to WRITEBACK.
    - Miss on a clean or invalid line: go to ALLOCATE.
    - `proc_stall = 1` in the miss cycle.
  - WRITEBACK:
    - Drives `mem_write = 1`, `mem_addr = {stored tag, index}` and `mem_wdata` = the stored block.
    - On `mem_ready`, go to ALLOCATE.
  - ALLOCATE:
    - Drives `mem_read = 1` and `mem_addr = proc_addr[29:2]`.
    - On `mem_ready`, the line is loaded with `mem_rdata`, the request tag, `valid = 1` and `dirty = 0`; go to COMPARE.
  - In WRITEBACK and ALLOCATE, `proc_stall = 1` every cycle.
- After a fill, the request hits in COMPARE. A pending write then merges into the freshly filled line and sets `dirty`.
- `proc_rdata` always shows the selected word of the indexed line. It is meaningful only when `proc_read = 1` and `proc_stall = 0`.
- `proc_read` and `proc_write` both high: treated as a write.
- The processor holds `proc_read`, `proc_write`, `proc_addr` and `proc_wdata` stable while `proc_stall = 1`; the cache does not latch them.

## Timing
- Reset (asynchronous, while `rst_n = 0`):
  - State = COMPARE.
  - All `valid` and `dirty` bits cleared; all tags and data cleared to 0.
  - `mem_read = 0`, `mem_write = 0`, `mem_addr = 0`, `mem_wdata = 0`.
  - `proc_stall = 0` unless a request is present.
  - `proc_rdata = 0`.
- Hit latency: 0 wait cycles. The stall is low in the same cycle as the request.
- Memory handshake:
  - `mem_read` / `mem_write` are registered and assert in the first cycle of ALLOCATE / WRITEBACK.
  - Address and data are held stable until the cycle `mem_ready` is sampled high.
  - The request deasserts in the next cycle.
  - Never both high at once.
  - `mem_ready` outside a request is ignored.
- Clean read miss with `mem_ready` arriving `L` cycles after `mem_read` rises (`L ≥ 1`): `proc_stall` is high for `L + 2` cycles (miss cycle, `L` ALLOCATE cycles that end with the ready cycle, then the data is available on the next cycle).
- Dirty miss: add the WRITEBACK cycles, which also end with a `mem_ready`.
- Reset asserted mid-WRITEBACK or mid-ALLOCATE: immediately returns to COMPARE with all lines invalid and memory requests dropped. No partial fill remains.
- Tag and index compare uses the full `TW` and `IW` bits.
- Index wrap: addresses that differ only in tag map to the same line and conflict.

## Test plan
- Reset, then read address 0x0000_0005 (memory model `L = 1`) -> `mem_read` with `mem_addr = 0x0000001`; `proc_stall` high 3 cycles; `proc_rdata` = word 1 of the returned block.
- Write 0xDEADBEEF to 0x0000_0005 (hit), then read it back -> `proc_stall` is 0 on both accesses; `proc_rdata = 0xDEADBEEF`; no memory traffic.
- Read 0x0000_0025 (same index, different tag) after the dirty write -> `mem_write` with `mem_addr = 0x0000001` and the block containing 0xDEADBEEF, then `mem_read` with `mem_addr = 0x0000009`; the line becomes clean.
- Write miss to 0x0000_0042 -> fill from memory, then 0xCAFEF00D merges into word 2; the later eviction writes back the merged block.
- `mem_ready` delayed 7 cycles on a read miss -> `mem_read` and `mem_addr` held stable for all 7 cycles; `proc_stall` high for 9 cycles.
- Assert `rst_n` low in the 3rd ALLOCATE cycle -> `mem_read` drops asynchronously; after release, a read of the same address misses again.
